// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit scheduler slice.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid index
// strictly after the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [REQ_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [REQ_W-1:0]   o_idx,
  output logic               o_any
);
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Indices above the pointer win first; the second pass handles the wrap.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_valid[i] && (i > int'(i_ptr))) begin
        o_any = 1'b1;
        o_idx = REQ_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_valid[i]) begin
        o_any = 1'b1;
        o_idx = REQ_W'(i);
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between NUM_REQ requesters; each accepted
// word of 1-4 bytes is sent LSB-first, one tx_ok per byte.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0][WORD_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0][1:0]       i_req_nbytes,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [BYTE_W-1:0]             o_tx_data,
  output logic                          o_tx_ok,
  input  logic                          i_tx_busy,
  output logic [REQ_W-1:0]              o_grant_id,
  output logic                          o_idle
);
  sched_state_t       r_state, w_next;
  logic [WORD_W-1:0]  r_buf;
  logic [1:0]         r_cnt;
  logic [REQ_W-1:0]   r_grant, r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [REQ_W-1:0]   w_idx;
  logic               w_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_arb (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_any) w_next = ISSUE;
      ISSUE:     if (!i_tx_busy) w_next = WAIT_BUSY;
      WAIT_BUSY: if (i_tx_busy) w_next = WAIT_DONE;
      WAIT_DONE: if (!i_tx_busy) w_next = (r_cnt == 2'd0) ? IDLE : ISSUE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == IDLE) ? w_grant : '0;
    o_tx_ok     = (r_state == ISSUE) && !i_tx_busy;
    o_idle      = (r_state == IDLE);
  end

  // Pointer starts at the last index so requester 0 is first after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_ptr   <= REQ_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_buf   <= i_req_data[w_idx];
          r_cnt   <= i_req_nbytes[w_idx];
          r_grant <= w_idx;
          r_ptr   <= w_idx;
        end
        WAIT_DONE: if (!i_tx_busy && r_cnt != 2'd0) begin
          r_buf <= r_buf >> BYTE_W;
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data  = r_buf[BYTE_W-1:0];
  assign o_grant_id = r_grant;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a round-robin reference model predicts accept order and
// bytes; a monitor checks every req_ready and tx_ok against those queues.
module tb_uart_tx_scheduler;
  localparam int N  = 3;
  localparam int RW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0][31:0]  req_data;
  logic [N-1:0][1:0]   req_nbytes;
  logic [N-1:0]        req_ready;
  logic [7:0]          tx_data;
  logic                tx_ok, tx_busy;
  logic [RW-1:0]       grant_id;
  logic                idle;

  uart_tx_scheduler #(.NUM_REQ(N), .REQ_W(RW)) dut (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_nbytes(req_nbytes), .o_req_ready(req_ready), .o_tx_data(tx_data),
    .o_tx_ok(tx_ok), .i_tx_busy(tx_busy), .o_grant_id(grant_id), .o_idle(idle)
  );

  always #5 clk = ~clk;

  // Behavioural transmitter: start + 8 data + stop, each tx_int cycles.
  int         tx_int = 1;
  int         tx_cnt;
  int         bit_i;
  logic [9:0] frame;
  logic       force_busy = 1'b0;
  logic       tx_line;

  always @(posedge clk) begin
    if (reset) tx_cnt <= 0;
    else if (tx_cnt == 0 && tx_ok) begin
      tx_cnt <= 10 * tx_int;
      frame  <= {1'b1, tx_data, 1'b0};
    end else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = force_busy || (tx_cnt > 0);
  always_comb begin
    tx_line = 1'b1;
    bit_i   = 0;
    if (tx_cnt > 0) begin
      bit_i   = (10 * tx_int - tx_cnt) / tx_int;
      tx_line = frame[bit_i[3:0]];
    end
  end

  typedef struct packed { logic [RW-1:0] id; logic [7:0] b; } exp_t;
  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] wq[N][$];
  logic [1:0]  nq[N][$];
  int          m_ptr;
  int          n_checks = 0, n_fail = 0, tx_ok_cnt = 0;
  exp_t        mon_e;
  int          mon_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_ok) begin
        tx_ok_cnt++;
        chk("tx_ok_while_busy", 64'(tx_busy), 0);
        if (exp_q.size() == 0) chk("unexpected_tx_ok", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("tx_data", 64'(tx_data), 64'(mon_e.b));
          chk("grant_id", 64'(grant_id), 64'(mon_e.id));
        end
      end
      if (req_ready != '0) begin
        chk("ready_without_valid", 64'(req_ready & ~req_valid), 0);
        if (acc_q.size() == 0) chk("unexpected_req_ready", 64'(req_ready), 0);
        else begin
          mon_a = acc_q.pop_front();
          chk("req_ready", 64'(req_ready), 64'(1) << mon_a);
        end
      end
    end
  end

  // Reference: every queued word is pending at once; serve round-robin from m_ptr.
  task automatic model_push();
    int rem[N];
    int total = 0;
    logic [31:0] w;
    for (int i = 0; i < N; i++) begin rem[i] = wq[i].size(); total += rem[i]; end
    while (total > 0) begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr + k) % N;
        if (rem[i] > 0) begin
          int idx = wq[i].size() - rem[i];
          w = wq[i][idx];
          acc_q.push_back(i);
          for (int j = 0; j <= int'(nq[i][idx]); j++) exp_q.push_back({RW'(i), w[8*j +: 8]});
          rem[i]--; total--; m_ptr = i;
          break;
        end
      end
    end
  endtask

  task automatic drive(input int budget);
    int cyc = 0;
    logic [N-1:0] rdy;
    model_push();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (wq[i].size() > 0);
      if (wq[i].size() > 0) begin req_data[i] = wq[i][0]; req_nbytes[i] = nq[i][0]; end
    end
    while (cyc < budget) begin
      @(negedge clk);
      rdy = req_ready & req_valid;
      if (req_valid == '0 && exp_q.size() == 0 && idle) break;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && wq[i].size() > 0) begin
          void'(wq[i].pop_front()); void'(nq[i].pop_front());
          if (wq[i].size() > 0) begin req_data[i] = wq[i][0]; req_nbytes[i] = nq[i][0]; end
          else req_valid[i] = 1'b0;
        end
      end
      cyc++;
    end
    chk("drain_in_budget", 64'(cyc < budget), 1);
    chk("idle_after_drain", 64'(idle), 1);
  endtask

  task automatic add(input int r, input logic [31:0] w, input logic [1:0] nb);
    wq[r].push_back(w); nq[r].push_back(nb);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bits[10];
    bits = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    reset = 1'b1; req_valid = '0; req_data = '0; req_nbytes = '0; m_ptr = N - 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_tx_ok", 64'(tx_ok), 0);
    chk("rst_tx_data", 64'(tx_data), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_idle", 64'(idle), 1);

    // Single 4-byte word
    add(0, 32'h44332211, 2'd3);
    drive(400);

    // Round-robin between two continuously requesting sources
    add(0, 32'hA0, 0); add(0, 32'hA0, 0);
    add(1, 32'hB1, 0); add(1, 32'hB1, 0);
    drive(400);

    // Real-timing line check, interval 4
    tx_int = 4; base = tx_ok_cnt;
    add(0, 32'h55, 0);
    fork
      drive(400);
      begin
        int w = 0;
        while (!tx_ok && w < 50) begin @(negedge clk); w++; end
        chk("uart_tx_ok_seen", 64'(tx_ok), 1);
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("uart_line", 64'(tx_line), 64'(bits[b]));
          end
      end
    join
    repeat (5) @(negedge clk);
    chk("uart_single_tx_ok", 64'(tx_ok_cnt - base), 1);
    tx_int = 1;

    // Stale busy during grant
    force_busy = 1'b1; base = tx_ok_cnt;
    add(2, 32'hC3, 0);
    fork
      drive(400);
      begin
        repeat (6) @(negedge clk);
        chk("stale_no_tx_ok", 64'(tx_ok_cnt - base), 0);
        chk("stale_not_idle", 64'(idle), 0);
        @(posedge clk); #1 force_busy = 1'b0;
        @(negedge clk);
        chk("tx_ok_after_release", 64'(tx_ok), 1);
      end
    join

    // Withdrawn request while another word is in flight
    add(0, 32'hDEADBEEF, 2'd3);
    fork
      drive(400);
      begin
        repeat (5) @(posedge clk);
        #1 req_valid[1] = 1'b1; req_data[1] = 32'h77;
        @(posedge clk); #1 req_valid[1] = 1'b0;
      end
    join

    // Reset after the second byte of a four-byte word
    base = tx_ok_cnt;
    add(0, 32'h0D0C0B0A, 2'd3);
    fork
      drive(400);
      begin
        int w = 0;
        while (tx_ok_cnt < base + 2 && w < 200) begin @(negedge clk); w++; end
        chk("two_bytes_before_reset", 64'(tx_ok_cnt - base), 2);
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete(); acc_q.delete(); m_ptr = N - 1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_ok", 64'(tx_ok), 0);
        chk("post_rst_idle", 64'(idle), 1);
      end
    join
    add(1, 32'h11, 0); add(0, 32'h22, 0);
    drive(400);

    // Randomized rounds
    for (int it = 0; it < 12; it++) begin
      tx_int = $urandom_range(1, 2);
      for (int i = 0; i < N; i++) begin
        int n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) add(i, $urandom, 2'($urandom_range(0, 3)));
      end
      drive(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
